// File: rtl/swc_pkg.sv
// Shared types and constants for the instruction buffer slice.
package swc_pkg;

  localparam int SWC_XLEN = 32;
  localparam logic [31:0] SWC_NOP = 32'h0000_0013;

  typedef struct packed {
    logic                err;
    logic [SWC_XLEN-1:0] pc;
    logic [SWC_XLEN-1:0] inst;
  } ibuf_entry_t;

endpackage

// File: rtl/ifu_ibuf_mem.sv
// DEPTH-entry storage for the instruction buffer: one write port, one async read port.
module ifu_ibuf_mem
  import swc_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        hclk,
  input  logic        we_i,
  input  logic [AW-1:0] waddr_i,
  input  ibuf_entry_t wdata_i,
  input  logic [AW-1:0] raddr_i,
  output ibuf_entry_t rdata_o
);

  ibuf_entry_t mem_q [DEPTH];

  // Data carries no reset; validity is tracked by the occupancy count in the top.
  always_ff @(posedge hclk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ifu_ibuf_swc.sv
// Fetch-to-decode instruction buffer with skid-aware stall, flush and sticky overflow.
// Optional same-cycle bypass when empty is enabled by defining IBUF_BYPASS_EN.
module ifu_ibuf_swc
  import swc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SKID  = 1,
  parameter int XLEN  = SWC_XLEN,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic            hclk,
  input  logic            hrstn,
  input  logic            ifu_valid,
  input  logic [XLEN-1:0] ifu_pc,
  input  logic [XLEN-1:0] ifu_inst,
  input  logic            ifu_err,
  input  logic            flush,
  output logic            ifu_dec_stall,
  output logic            dec_valid,
  output logic [XLEN-1:0] dec_pc,
  output logic [XLEN-1:0] dec_inst,
  output logic            dec_err,
  input  logic            dec_ready,
  output logic [CW-1:0]   ibuf_count,
  output logic            ibuf_ovf
);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_TH = CW'(DEPTH - SKID);

  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          stall_q, stall_d, ovf_q, ovf_d;
  logic          full, byp, pop, push, byp_take, wr_en, rd_adv;
  ibuf_entry_t   head, wr_entry;

  assign wr_entry.err  = ifu_err;
  assign wr_entry.pc   = SWC_XLEN'(ifu_pc);
  assign wr_entry.inst = SWC_XLEN'(ifu_inst);

  ifu_ibuf_mem #(.DEPTH(DEPTH)) u_mem (
    .hclk    (hclk),
    .we_i    (wr_en),
    .waddr_i (wptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rptr_q),
    .rdata_o (head)
  );

  assign full = (count_q == DEPTH_C);

`ifdef IBUF_BYPASS_EN
  assign byp = (count_q == '0) & ~flush;
`else
  assign byp = 1'b0;
`endif

  always_comb begin
    dec_valid = (count_q != '0);
    dec_pc    = XLEN'(head.pc);
    dec_inst  = XLEN'(head.inst);
    dec_err   = head.err;
    if (byp) begin
      dec_valid = ifu_valid;
      dec_pc    = ifu_pc;
      dec_inst  = ifu_inst;
      dec_err   = ifu_err;
    end
    if (!dec_valid) begin
      dec_pc   = '0;
      dec_inst = XLEN'(SWC_NOP);
      dec_err  = 1'b0;
    end
  end

  assign pop  = dec_valid & dec_ready;
  assign push = ifu_valid & ~flush & (~full | pop);
  // A bypassed entry consumed this cycle never touches storage.
  assign byp_take = byp & pop;
  assign wr_en    = push & ~byp_take;
  assign rd_adv   = pop & ~byp_take;

  always_comb begin
    wptr_d  = wptr_q + AW'(wr_en);
    rptr_d  = rptr_q + AW'(rd_adv);
    count_d = count_q + CW'(wr_en) - CW'(rd_adv);
    ovf_d   = ovf_q | (ifu_valid & ~flush & full & ~pop);
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
    stall_d = ~flush & (count_d >= STALL_TH);
  end

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      stall_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      stall_q <= stall_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ifu_dec_stall = stall_q;
  assign ibuf_count    = count_q;
  assign ibuf_ovf      = ovf_q;

endmodule
